fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single write port of one FIFO (e.g. fifo_64) among NUM_REQ requesters. Each requester presents data with a request; the arbiter grants one requester at a time for a burst of up to MAX_BURST words, gates transfers on FIFO full, and rotates priority fairly. It sits directly in front of the FIFO write side and drives its write enable and data.

---
 rtl/fifo_wr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter in front of one FIFO
// write port.
//
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset
//   i_req              per-requester word-valid / request
//   i_req_data         requester k word at [k*WIDTH +: WIDTH]
//   o_gnt              registered one-hot grant (0 when idle)
//   o_ack              per-requester word-accepted strobe
//   i_fifo_full        FIFO full flag
//   o_fifo_wr_en       FIFO write enable
//   o_fifo_wr_data     FIFO write data
//   o_busy             high while a grant is held
//   o_stall_cnt        saturating count of full-blocked cycles
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int STALL_W   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic [NUM_REQ-1:0]       o_ack,
  input  logic                     i_fifo_full,
  output logic                     o_fifo_wr_en,
  output logic [WIDTH-1:0]         o_fifo_wr_data,
  output logic                     o_busy,
  output logic [STALL_W-1:0]       o_stall_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [IDX_W-1:0] LAST_RST =
    IDX_W'(NUM_REQ - 1);

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic [IDX_W-1:0]   base;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [NUM_REQ-1:0] pick_oh;
  logic [WIDTH-1:0]   data_sel;
  logic [CNT_W-1:0]   cnt_inc;
  logic               cur_req;
  logic               rel;

  // While granted, the holder is the "last served" for the
  // re-pick on release, so it searches from the holder.
  always_comb begin
    int j;
    j        = 0;
    base     = (state_q == ST_GRANT) ? gidx_q : last_q;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = int'(base) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!pick_vld && i_req[IDX_W'(j)]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
    pick_oh = '0;
    pick_oh[pick_idx] = pick_vld;
  end

  // AND-OR mux keyed on the one-hot grant gives 0 when idle.
  always_comb begin
    data_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_q[k]) data_sel = i_req_data[k*WIDTH +: WIDTH];
    end
  end

  assign o_ack = gnt_q & i_req & ~{NUM_REQ{i_fifo_full}};
  assign o_fifo_wr_en   = |o_ack;
  assign o_fifo_wr_data = data_sel;
  assign o_gnt          = gnt_q;
  assign o_busy         = (state_q == ST_GRANT);
  assign o_stall_cnt    = stall_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    cnt_inc = cnt_q + CNT_W'(1);
    cur_req = i_req[gidx_q];
    rel     = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (pick_vld) begin
          state_d = ST_GRANT;
          gnt_d   = pick_oh;
          gidx_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      (state_q == ST_GRANT): begin
        if (!cur_req) begin
          rel = 1'b1;
        end else if (i_fifo_full) begin
          if (stall_q != '1) begin
            stall_d = stall_q + STALL_W'(1);
          end
        end else if (cnt_inc == CNT_W'(MAX_BURST)) begin
          rel = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
        // Re-pick in the same cycle so back-to-back
        // grants have no idle bubble.
        if (rel) begin
          last_d = gidx_q;
          cnt_d  = '0;
          if (pick_vld) begin
            gnt_d  = pick_oh;
            gidx_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed stimulus with a write scoreboard
// for fifo_wr_arbiter, plus a MAX_BURST=1 / STALL_W=3 instance.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        full;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        busy;
  logic [15:0] stall;

  logic [3:0]  req2;
  logic [31:0] data2 = 32'h4433_2211;
  logic        full2;
  logic [3:0]  gnt2;
  logic [3:0]  ack2;
  logic        wr_en2;
  logic [7:0]  wr_data2;
  logic        busy2;
  logic [2:0]  stall2;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] ack;
    logic [7:0] data;
  } exp_t;

  exp_t       expq[$];
  exp_t       mon_e;
  logic [3:0] ack_smp;
  logic [3:0] sent[4];
  int         ac[4];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ(4), .WIDTH(8), .MAX_BURST(4), .STALL_W(16)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req(req), .i_req_data(req_data),
    .o_gnt(gnt), .o_ack(ack),
    .i_fifo_full(full),
    .o_fifo_wr_en(wr_en), .o_fifo_wr_data(wr_data),
    .o_busy(busy), .o_stall_cnt(stall)
  );

  fifo_wr_arbiter #(
    .NUM_REQ(4), .WIDTH(8), .MAX_BURST(1), .STALL_W(3)
  ) u_sat (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req(req2), .i_req_data(data2),
    .o_gnt(gnt2), .o_ack(ack2),
    .i_fifo_full(full2),
    .o_fifo_wr_en(wr_en2), .o_fifo_wr_data(wr_data2),
    .o_busy(busy2), .o_stall_cnt(stall2)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic push(input int k, input int d);
    exp_t e;
    e.ack  = 4'(1 << k);
    e.data = 8'(d);
    expq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    full  = 1'b0;
    req2  = '0;
    full2 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Requester k presents word {k, words already accepted}.
  always_comb begin
    req_data = '0;
    for (int k = 0; k < 4; k++) begin
      req_data[k*8 +: 8] = {4'(k), sent[k]};
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) sent[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (ack_smp[k]) sent[k] <= sent[k] + 4'd1;
      end
    end
  end

  // Monitor: every FIFO write must match the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack_smp <= '0;
    end else begin
      ack_smp <= ack;
      if (wr_en) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexp_write: got %0h/%b want none",
                   wr_data, ack);
        end else begin
          mon_e = expq.pop_front();
          chk("wr_data", 32'(wr_data), 32'(mon_e.data));
          chk("wr_ack", 32'(ack), 32'(mon_e.ack));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);

    // single requester: regranted with no bubble
    req = 4'b0010;
    for (int j = 0; j < 8; j++) push(1, 'h10 + j);
    tick();
    chk("t1_gnt", 32'(gnt), 32'h2);
    for (int i = 0; i < 8; i++) begin
      chk("t1_wr_en", 32'(wr_en), 32'h1);
      chk("t1_gnt_hold", 32'(gnt), 32'h2);
      tick();
    end
    req = '0;
    tick();
    tick();
    chk("t1_idle_gnt", 32'(gnt), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);

    // all requesting: order 0,1,2,3, four words each
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      ac[k] = 0;
      for (int j = 0; j < 4; j++) push(k, (k << 4) | j);
    end
    tick();
    chk("t2_gnt0", 32'(gnt), 32'h1);
    for (int i = 0; i < 16; i++) begin
      chk("t2_wr_en", 32'(wr_en), 32'h1);
      for (int k = 0; k < 4; k++) if (ack[k]) ac[k]++;
      tick();
    end
    req = '0;
    tick();
    tick();
    for (int k = 0; k < 4; k++) chk("t2_ack_cnt", ac[k], 4);

    // full stall mid-burst, then rotation to req 3
    do_reset();
    req = 4'b0100;
    for (int j = 0; j < 4; j++) push(2, 'h20 + j);
    for (int j = 0; j < 4; j++) push(3, 'h30 + j);
    tick();
    chk("t3_gnt", 32'(gnt), 32'h4);
    tick();
    tick();
    full = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_full_wr_en", 32'(wr_en), 32'h0);
      chk("t3_full_gnt", 32'(gnt), 32'h4);
      tick();
    end
    chk("t3_stall", 32'(stall), 32'd5);
    full = 1'b0;
    req  = 4'b1100;
    tick();
    tick();
    chk("t3_rot_gnt", 32'(gnt), 32'h8);
    repeat (4) tick();
    req = '0;
    tick();
    tick();

    // drop before ack forfeits the grant
    do_reset();
    req = 4'b1001;
    push(0, 'h00);
    for (int j = 0; j < 4; j++) push(3, 'h30 + j);
    tick();
    chk("t4_gnt0", 32'(gnt), 32'h1);
    tick();
    req = 4'b1000;
    #1;
    chk("t4_drop_wr_en", 32'(wr_en), 32'h0);
    tick();
    chk("t4_gnt3", 32'(gnt), 32'h8);
    repeat (4) tick();
    req = '0;
    tick();
    tick();
    chk("t4_idle_gnt", 32'(gnt), 32'h0);

    // async reset mid-burst
    do_reset();
    req = 4'b0010;
    tick();
    full = 1'b1;
    tick();
    chk("t5_stall1", 32'(stall), 32'd1);
    full = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_ar_gnt", 32'(gnt), 32'h0);
    chk("t5_ar_ack", 32'(ack), 32'h0);
    chk("t5_ar_wr_en", 32'(wr_en), 32'h0);
    chk("t5_ar_stall", 32'(stall), 32'h0);
    req = 4'b0011;
    tick();
    tick();
    rst_n = 1'b1;
    push(0, 'h00);
    tick();
    chk("t5_gnt0", 32'(gnt), 32'h1);
    tick();
    req = '0;
    tick();
    tick();

    // MAX_BURST=1: alternation and 3-bit stall saturation
    do_reset();
    req2 = 4'b0101;
    tick();
    chk("t6_gnt_a", 32'(gnt2), 32'h1);
    chk("t6_wr_en", 32'(wr_en2), 32'h1);
    tick();
    chk("t6_gnt_b", 32'(gnt2), 32'h4);
    tick();
    chk("t6_gnt_c", 32'(gnt2), 32'h1);
    tick();
    chk("t6_gnt_d", 32'(gnt2), 32'h4);
    full2 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) chk("t6_stall3", 32'(stall2), 32'd3);
      if (i == 7) chk("t6_stall7", 32'(stall2), 32'd7);
    end
    chk("t6_stall_sat", 32'(stall2), 32'd7);
    chk("t6_hold_gnt", 32'(gnt2), 32'h4);
    chk("t6_full_wr_en", 32'(wr_en2), 32'h0);
    full2 = 1'b0;
    req2  = '0;
    tick();
    tick();

    chk("queue_drain", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
